seq_mult_mac: RTL and testbench

- Parametrised sequential shift-add multiplier with optional multiply-accumulate.
- Supports unsigned and two's-complement operands, selected per transaction.
- Uses valid/ready handshakes on both input and output, with early termination once the remaining multiplier bits are zero.
- Sits between a register-mapped operand source and a result consumer; it is the drop-in next generation of the team's 4-bit ASMD multiplier.

---
 rtl/seq_mult_mac.sv | 185 ++++++++++++++++++
 tb/tb_seq_mult_mac.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_mac.sv
// -----------------------------------------------------------------------------
// seq_mult_mac
//   Sequential shift-add multiplier with optional multiply-accumulate.
//   It retires one multiplier bit per cycle and stops as soon as the remaining
//   multiplier bits are all zero. Operands are unsigned or two's complement,
//   selected per transaction. The core multiplies magnitudes, and the FIX state
//   applies the sign of the product.
//
// Ports
//   clk, reset          rising-edge clock; asynchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready high only in IDLE)
//   a, b                multiplicand / multiplier (WIDTH bits)
//   signed_mode         1 = operands are two's complement
//   acc_en              add this product into the accumulator
//   acc_clr             clear accumulator (and overflow flag) before the add
//   out_valid/out_ready result handshake
//   result              2*WIDTH-bit product
//   acc_out             ACC_W-bit accumulator
//   acc_ovf             sticky accumulator overflow / carry-out flag
//   busy                block is not in IDLE
// -----------------------------------------------------------------------------
module seq_mult_mac #(
    parameter int WIDTH     = 8,
    parameter int ACC_GUARD = 4,
    localparam int ACC_W    = 2*WIDTH + ACC_GUARD
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    input  logic               acc_en,
    input  logic               acc_clr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic [ACC_W-1:0]   acc_out,
    output logic               acc_ovf,
    output logic               busy
);

    localparam int PW = 2*WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_reg;
    logic [PW-1:0]    mcand_reg;
    logic [PW-1:0]    partial_reg;
    logic [PW-1:0]    result_reg;
    logic [WIDTH-1:0] mplier_reg;
    logic             signed_reg;
    logic             acc_en_reg;
    logic             acc_clr_reg;
    logic             neg_reg;
    logic [ACC_W-1:0] acc_reg;
    logic             ovf_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic             busy_reg;

    // Operand magnitudes. The most negative value maps onto itself, and read
    // as unsigned it is exactly the right magnitude.
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    always_comb begin
        mag_a = (signed_mode && a[WIDTH-1]) ? (WIDTH'(0) - a) : a;
        mag_b = (signed_mode && b[WIDTH-1]) ? (WIDTH'(0) - b) : b;
    end

    // FIX-state datapath: signed product, accumulator base and the add.
    logic [PW-1:0]    fix_result;
    logic [ACC_W-1:0] acc_base;
    logic [ACC_W-1:0] acc_ext;
    logic [ACC_W-1:0] acc_sum;
    logic [ACC_W:0]   sum_wide;
    logic             ovf_base;
    logic             add_ovf;

    always_comb begin
        fix_result = neg_reg ? (PW'(0) - partial_reg) : partial_reg;
        // acc_clr acts before the add, so it zeroes both the base value and
        // the sticky flag that this add's overflow is ORed into.
        acc_base   = acc_clr_reg ? '0 : acc_reg;
        ovf_base   = acc_clr_reg ? 1'b0 : ovf_reg;
        acc_ext    = signed_reg ? ACC_W'($signed(fix_result)) : ACC_W'(fix_result);
        sum_wide   = {1'b0, acc_base} + {1'b0, acc_ext};
        acc_sum    = sum_wide[ACC_W-1:0];
        // Signed overflow: operands of equal sign and a result of the other sign.
        add_ovf    = signed_reg
                   ? ((acc_base[ACC_W-1] == acc_ext[ACC_W-1]) &&
                      (acc_sum[ACC_W-1]  != acc_base[ACC_W-1]))
                   : sum_wide[ACC_W];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            mcand_reg     <= '0;
            partial_reg   <= '0;
            result_reg    <= '0;
            mplier_reg    <= '0;
            signed_reg    <= 1'b0;
            acc_en_reg    <= 1'b0;
            acc_clr_reg   <= 1'b0;
            neg_reg       <= 1'b0;
            acc_reg       <= '0;
            ovf_reg       <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        signed_reg   <= signed_mode;
                        acc_en_reg   <= acc_en;
                        acc_clr_reg  <= acc_clr;
                        neg_reg      <= signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
                        mcand_reg    <= PW'(mag_a);
                        mplier_reg   <= mag_b;
                        partial_reg  <= '0;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        // A zero operand skips the shift-add loop entirely.
                        state_reg    <= ((mag_a == '0) || (mag_b == '0)) ? FIX : RUN;
                    end
                end

                RUN: begin
                    if (mplier_reg[0]) begin
                        partial_reg <= partial_reg + mcand_reg;
                    end
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    // Early exit: the shifted multiplier has no set bits left.
                    if (mplier_reg[WIDTH-1:1] == '0) begin
                        state_reg <= FIX;
                    end
                end

                FIX: begin
                    result_reg <= fix_result;
                    if (acc_en_reg) begin
                        acc_reg <= acc_sum;
                        ovf_reg <= ovf_base | add_ovf;
                    end else if (acc_clr_reg) begin
                        acc_reg <= '0;
                        ovf_reg <= 1'b0;
                    end
                    out_valid_reg <= 1'b1;
                    state_reg     <= DONE;
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign result    = result_reg;
    assign acc_out   = acc_reg;
    assign acc_ovf   = ovf_reg;

endmodule

// File: tb/tb_seq_mult_mac.sv
// -----------------------------------------------------------------------------
// tb_seq_mult_mac
//   Scoreboard bench for seq_mult_mac (WIDTH=8, ACC_GUARD=4). The driver
//   computes the expected product, accumulator, overflow flag and latency with
//   plain integer arithmetic and pushes them into a queue. A monitor pops one
//   entry each time the DUT raises out_valid and compares it with the outputs.
//   Latency counts rising edges from the accept edge (which counts as 1) up to
//   the edge after which out_valid is high.
// -----------------------------------------------------------------------------
module tb_seq_mult_mac;

    localparam int W  = 8;
    localparam int G  = 4;
    localparam int AW = 2*W + G;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          signed_mode;
    logic          acc_en;
    logic          acc_clr;
    logic          out_valid;
    logic          out_ready;
    logic [2*W-1:0] result;
    logic [AW-1:0] acc_out;
    logic          acc_ovf;
    logic          busy;

    seq_mult_mac #(.WIDTH(W), .ACC_GUARD(G)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .acc_en      (acc_en),
        .acc_clr     (acc_clr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .acc_out     (acc_out),
        .acc_ovf     (acc_ovf),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*W-1:0] res;
        logic [AW-1:0]  acc;
        logic           ovf;
        int             lat;
        int             acc_cyc;
    } exp_t;

    exp_t   exp_q[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc    = 0;
    longint acc_m  = 0;
    bit     ovf_m  = 0;
    bit     rand_ready  = 0;
    bit     ready_force = 1;
    bit     holding  = 0;
    bit     idle_next = 0;
    logic [2*W-1:0] held_res;
    logic [AW-1:0]  held_acc;
    exp_t   mon_e;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // out_ready is owned by this process only; it updates 2 time units after
    // each rising edge so that values set by the main flow at +1 take effect.
    always @(posedge clk) begin
        #2;
        out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
    end

    // Reference model: the true product and accumulator computed as integers.
    function automatic int bitlen(input longint v);
        int n = 0;
        while (v != 0) begin
            v = v >> 1;
            n++;
        end
        return n;
    endfunction

    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input bit sm, input bit en, input bit clr);
        exp_t   e;
        longint pa, pb, prod, sum, sbase;
        longint full   = longint'(1) << AW;
        longint half   = longint'(1) << (AW - 1);
        if (sm) begin
            pa = longint'($signed(av));
            pb = longint'($signed(bv));
        end else begin
            pa = longint'(av);
            pb = longint'(bv);
        end
        prod  = pa * pb;
        e.res = prod[2*W-1:0];
        if (pa == 0 || pb == 0) e.lat = 2;
        else                    e.lat = bitlen(pb < 0 ? -pb : pb) + 2;
        if (clr) begin
            acc_m = 0;
            ovf_m = 0;
        end
        if (en) begin
            if (sm) begin
                sbase = (acc_m >= half) ? acc_m - full : acc_m;
                sum   = sbase + prod;
                if (sum < -half || sum >= half) ovf_m = 1;
            end else begin
                sum = acc_m + prod;
                if (sum >= full) ovf_m = 1;
            end
            acc_m = sum & (full - 1);
        end
        e.acc     = acc_m[AW-1:0];
        e.ovf     = ovf_m;
        e.acc_cyc = 0;
        return e;
    endfunction

    // Monitor: compares on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            holding   = 0;
            idle_next = 0;
        end else if (out_valid) begin
            if (!holding) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 64'd1, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("result",  64'(result),  64'(mon_e.res));
                    chk("acc_out", 64'(acc_out), 64'(mon_e.acc));
                    chk("acc_ovf", 64'(acc_ovf), 64'(mon_e.ovf));
                    chk("latency", 64'(cyc - mon_e.acc_cyc + 1), 64'(mon_e.lat));
                    chk("in_ready_in_done", 64'(in_ready), 64'd0);
                    $display("txn res=%h acc=%h ovf=%0b lat=%0d", result, acc_out, acc_ovf,
                             cyc - mon_e.acc_cyc + 1);
                end
                holding  = 1;
                held_res = result;
                held_acc = acc_out;
            end else begin
                chk("hold_result", 64'(result),  64'(held_res));
                chk("hold_acc",    64'(acc_out), 64'(held_acc));
            end
            if (out_ready) begin
                holding   = 0;
                idle_next = 1;
            end
        end else if (idle_next) begin
            chk("in_ready_after_handshake", 64'(in_ready), 64'd1);
            chk("busy_after_handshake",     64'(busy),     64'd0);
            idle_next = 0;
        end
    end

    // Driver: called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input bit sm, input bit en, input bit clr);
        exp_t e;
        int   n = 0;
        while (!in_ready) begin
            @(posedge clk); #1;
            n++;
            if (n > 500) begin
                chk("in_ready_timeout", 64'd0, 64'd1);
                return;
            end
        end
        a = av; b = bv; signed_mode = sm; acc_en = en; acc_clr = clr;
        in_valid  = 1'b1;
        e         = model(av, bv, sm, en, clr);
        e.acc_cyc = cyc + 1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        signed_mode = 1'($urandom);
        acc_en  = 1'($urandom);
        acc_clr = 1'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 || !in_ready || holding) begin
            @(posedge clk); #1;
            n++;
            if (n > 500) begin
                chk("idle_timeout", 64'd0, 64'd1);
                return;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb;
        int n;
        reset = 1'b1; in_valid = 1'b0; a = '0; b = '0;
        signed_mode = 1'b0; acc_en = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_result",    64'(result),    64'd0);
        chk("rst_acc",       64'(acc_out),   64'd0);
        chk("rst_ovf",       64'(acc_ovf),   64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed products and latencies.
        send(8'hFF, 8'hFF, 0, 0, 0); wait_idle();
        chk("ff_ff_result", 64'(result), 64'hFE01);
        send(8'h80, 8'h80, 1, 0, 0); wait_idle();
        chk("m128_sq_result", 64'(result), 64'h4000);
        send(8'hFD, 8'h05, 1, 0, 0); wait_idle();
        chk("m3_x5_result", 64'(result), 64'hFFF1);
        send(8'h37, 8'h00, 0, 0, 0); wait_idle();
        chk("b_zero_result", 64'(result), 64'h0);
        send(8'h00, 8'hFF, 0, 0, 0); wait_idle();
        chk("a_zero_result", 64'(result), 64'h0);

        // Unsigned MAC run up to overflow, then cleared.
        send(8'h10, 8'h10, 0, 1, 1); wait_idle();
        chk("mac_first_acc", 64'(acc_out), 64'h00100);
        send(8'hFF, 8'hFF, 0, 1, 0); wait_idle();
        chk("mac_second_acc", 64'(acc_out), 64'h0FF01);
        for (int i = 0; i < 16; i++) send(8'hFF, 8'hFF, 0, 1, 0);
        wait_idle();
        chk("mac_ovf_set", 64'(acc_ovf), 64'd1);
        send(8'h01, 8'h01, 0, 1, 1); wait_idle();
        chk("mac_ovf_cleared", 64'(acc_ovf), 64'd0);
        chk("mac_clr_acc",     64'(acc_out), 64'd1);

        // Backpressure: hold out_ready low in DONE and offer a stray operand.
        ready_force = 0;
        send(8'h12, 8'h34, 0, 1, 0);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_reached_done", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a = W'($urandom); b = W'($urandom);
            @(posedge clk); #1;
            chk("bp_in_ready_low", 64'(in_ready),  64'd0);
            chk("bp_out_valid",    64'(out_valid), 64'd1);
        end
        in_valid    = 1'b0;
        ready_force = 1;
        wait_idle();

        // Reset in the third RUN cycle of 0xAA*0xF0 aborts the operation.
        send(8'hAA, 8'hF0, 0, 1, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_acc",       64'(acc_out),   64'd0);
        chk("abort_in_ready",  64'(in_ready),  64'd1);
        chk("abort_ovf",       64'(acc_ovf),   64'd0);
        exp_q.delete();
        acc_m = 0;
        ovf_m = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        send(8'd3, 8'd4, 0, 0, 0); wait_idle();
        chk("after_abort_result", 64'(result), 64'd12);

        // Randomised traffic with random consumer backpressure.
        rand_ready = 1;
        for (int i = 0; i < 200; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: ra = '0;
                2: rb = W'($urandom_range(1, 7));
                3: begin ra = 8'h80; rb = 8'h80; end
                default: ;
            endcase
            send(ra, rb, 1'($urandom), 1'($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 9) == 0));
        end
        wait_idle();
        rand_ready  = 0;
        ready_force = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
